// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: tracks five in-flight conditional branches by one-hot
// speculative tag and resolves them against the execute-stage outcome.
`ifndef GSH_BHR_WIDTH
`define GSH_BHR_WIDTH 8
`endif

module branch_resolve_unit #(
    parameter int BHRW = `GSH_BHR_WIDTH
) (
    input  logic            i_clk,
    input  logic            i_resetn,
    input  logic            alloc_req,
    input  logic [31:0]     alloc_pc,
    input  logic            alloc_pred_cond,
    input  logic [31:0]     alloc_pred_target,
    input  logic [BHRW-1:0] alloc_bhr,
    output logic            alloc_ready,
    output logic [4:0]      alloc_tag,
    output logic [4:0]      spectagnow,
    input  logic            res_valid,
    input  logic [4:0]      res_tag,
    input  logic            res_taken,
    input  logic [31:0]     res_target,
    output logic            predict_hit,
    output logic            predict_miss,
    output logic [4:0]      predict_tag,
    output logic [31:0]     redirect_pc,
    output logic            btbpht_we,
    output logic [31:0]     btbpht_pc,
    output logic [31:0]     btb_jmpdst,
    output logic            pht_wcond,
    output logic [BHRW-1:0] pht_bhr,
    output logic [4:0]      mpft_valid
);
    localparam int N = 5;

    logic [4:0]      r_valid;
    logic [4:0]      r_older [N];
    logic [31:0]     r_pc    [N];
    logic [31:0]     r_ptgt  [N];
    logic [BHRW-1:0] r_bhr   [N];
    logic [4:0]      r_pcond;

    logic [4:0]      w_free;
    logic [4:0]      w_sel;
    logic            w_onehot;
    logic [2:0]      w_idx;
    logic            w_accept;
    logic            w_miss;
    logic [4:0]      w_kill;
    logic [4:0]      w_clear;
    logic            w_alloc;

    assign w_free   = ~r_valid;
    assign w_sel    = w_free & (~w_free + 5'd1);
    assign w_onehot = (res_tag != 5'd0) && ((res_tag & (res_tag - 5'd1)) == 5'd0);
    assign w_accept = res_valid & w_onehot & (|(res_tag & r_valid));
    assign w_miss   = w_accept & ((res_taken != r_pcond[w_idx]) |
                      (res_taken & (res_target != r_ptgt[w_idx])));

    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < N; i++)
            if (res_tag[i]) w_idx = 3'(i);
    end

    // younger branches carry the resolving tag in their older mask
    always_comb begin
        w_kill = res_tag;
        for (int j = 0; j < N; j++)
            if ((r_older[j] & res_tag) != 5'd0) w_kill[j] = 1'b1;
    end

    assign w_clear     = w_miss ? w_kill : (w_accept ? res_tag : 5'd0);
    assign alloc_ready = (|w_free) & ~w_miss;
    assign alloc_tag   = w_sel;
    assign spectagnow  = w_sel;
    assign w_alloc     = alloc_req & alloc_ready;
    assign mpft_valid  = r_valid;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_valid <= '0;
            r_pcond <= '0;
            for (int i = 0; i < N; i++) begin
                r_older[i] <= '0;
                r_pc[i]    <= '0;
                r_ptgt[i]  <= '0;
                r_bhr[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_alloc && w_sel[i]) begin
                    r_valid[i] <= 1'b1;
                    r_older[i] <= r_valid & ~w_clear;
                    r_pc[i]    <= alloc_pc;
                    r_pcond[i] <= alloc_pred_cond;
                    r_ptgt[i]  <= alloc_pred_target;
                    r_bhr[i]   <= alloc_bhr;
                end else begin
                    r_valid[i] <= r_valid[i] & ~w_clear[i];
                    r_older[i] <= r_older[i] & ~w_clear;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            predict_hit  <= 1'b0;
            predict_miss <= 1'b0;
            predict_tag  <= '0;
            redirect_pc  <= '0;
            btbpht_we    <= 1'b0;
            btbpht_pc    <= '0;
            btb_jmpdst   <= '0;
            pht_wcond    <= 1'b0;
            pht_bhr      <= '0;
        end else begin
            predict_hit  <= w_accept & ~w_miss;
            predict_miss <= w_miss;
            predict_tag  <= w_accept ? res_tag : 5'd0;
            redirect_pc  <= w_miss ? (res_taken ? res_target
                                     : r_pc[w_idx] + 32'd4) : 32'd0;
            btbpht_we    <= w_accept;
            btbpht_pc    <= w_accept ? r_pc[w_idx] : 32'd0;
            btb_jmpdst   <= w_accept ? res_target : 32'd0;
            pht_wcond    <= w_accept & res_taken;
            pht_bhr      <= w_accept ? r_bhr[w_idx] : '0;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus
// randomized traffic against an age-ordered behavioural model.
module tb_branch_resolve_unit;
    localparam int BHRW = 8;

    logic            i_clk = 1'b0;
    logic            i_resetn = 1'b0;
    logic            alloc_req = 1'b0;
    logic [31:0]     alloc_pc = '0;
    logic            alloc_pred_cond = 1'b0;
    logic [31:0]     alloc_pred_target = '0;
    logic [BHRW-1:0] alloc_bhr = '0;
    logic            alloc_ready;
    logic [4:0]      alloc_tag;
    logic [4:0]      spectagnow;
    logic            res_valid = 1'b0;
    logic [4:0]      res_tag = '0;
    logic            res_taken = 1'b0;
    logic [31:0]     res_target = '0;
    logic            predict_hit;
    logic            predict_miss;
    logic [4:0]      predict_tag;
    logic [31:0]     redirect_pc;
    logic            btbpht_we;
    logic [31:0]     btbpht_pc;
    logic [31:0]     btb_jmpdst;
    logic            pht_wcond;
    logic [BHRW-1:0] pht_bhr;
    logic [4:0]      mpft_valid;

    int checks = 0;
    int errors = 0;

    branch_resolve_unit #(.BHRW(BHRW)) dut (
        .i_clk(i_clk), .i_resetn(i_resetn),
        .alloc_req(alloc_req), .alloc_pc(alloc_pc),
        .alloc_pred_cond(alloc_pred_cond),
        .alloc_pred_target(alloc_pred_target), .alloc_bhr(alloc_bhr),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .spectagnow(spectagnow),
        .res_valid(res_valid), .res_tag(res_tag),
        .res_taken(res_taken), .res_target(res_target),
        .predict_hit(predict_hit), .predict_miss(predict_miss),
        .predict_tag(predict_tag), .redirect_pc(redirect_pc),
        .btbpht_we(btbpht_we), .btbpht_pc(btbpht_pc),
        .btb_jmpdst(btb_jmpdst), .pht_wcond(pht_wcond),
        .pht_bhr(pht_bhr), .mpft_valid(mpft_valid)
    );

    always #5 i_clk = ~i_clk;

    // model: each live branch remembers its allocation order number
    bit              m_valid [5];
    logic [31:0]     m_pc    [5];
    bit              m_cond  [5];
    logic [31:0]     m_tgt   [5];
    logic [BHRW-1:0] m_bhr   [5];
    int              m_seq   [5];
    int              m_cnt;
    logic            e_hit, e_miss, e_we, e_wcond;
    logic [4:0]      e_tag;
    logic [31:0]     e_redir, e_bpc, e_jmp;
    logic [BHRW-1:0] e_bhr;

    function automatic int m_free_idx();
        for (int i = 0; i < 5; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic logic [4:0] m_vec();
        logic [4:0] v;
        for (int i = 0; i < 5; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic int m_res_idx();
        if (!res_valid || $countones(res_tag) != 1) return -1;
        for (int i = 0; i < 5; i++)
            if (res_tag[i] && m_valid[i]) return i;
        return -1;
    endfunction

    function automatic bit m_miss_now();
        int k;
        k = m_res_idx();
        if (k < 0) return 1'b0;
        if (res_taken != m_cond[k]) return 1'b1;
        return res_taken && (res_target != m_tgt[k]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 5; i++) m_valid[i] = 1'b0;
        {e_hit, e_miss, e_we, e_wcond} = '0;
        e_tag = '0; e_redir = '0; e_bpc = '0; e_jmp = '0; e_bhr = '0;
    endtask

    task automatic model_edge();
        int k, f;
        bit mis;
        if (!i_resetn) begin
            model_clear();
            return;
        end
        k = m_res_idx();
        f = m_free_idx();
        mis = m_miss_now();
        {e_hit, e_miss, e_we, e_wcond} = '0;
        e_tag = '0; e_redir = '0; e_bpc = '0; e_jmp = '0; e_bhr = '0;
        if (k >= 0) begin
            e_hit = !mis; e_miss = mis; e_tag = res_tag; e_we = 1'b1;
            e_bpc = m_pc[k]; e_jmp = res_target; e_wcond = res_taken;
            e_bhr = m_bhr[k];
            if (mis) e_redir = res_taken ? res_target : m_pc[k] + 32'd4;
            if (mis) begin
                for (int j = 0; j < 5; j++)
                    if (j != k && m_valid[j] && m_seq[j] > m_seq[k])
                        m_valid[j] = 1'b0;
            end
            m_valid[k] = 1'b0;
        end
        if (alloc_req && f >= 0 && !mis) begin
            m_valid[f] = 1'b1; m_pc[f] = alloc_pc;
            m_cond[f] = alloc_pred_cond; m_tgt[f] = alloc_pred_target;
            m_bhr[f] = alloc_bhr; m_seq[f] = m_cnt; m_cnt++;
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        model_edge();
        #1;
        alloc_req = 1'b0;
        res_valid = 1'b0;
    endtask

    task automatic do_alloc(input logic [31:0] pc, input logic c,
                            input logic [31:0] t, input logic [BHRW-1:0] b);
        alloc_req = 1'b1; alloc_pc = pc; alloc_pred_cond = c;
        alloc_pred_target = t; alloc_bhr = b;
    endtask

    task automatic do_res(input logic [4:0] tag, input logic tk,
                          input logic [31:0] t);
        res_valid = 1'b1; res_tag = tag; res_taken = tk; res_target = t;
    endtask

    task automatic test_reset();
        i_resetn = 1'b0;
        model_clear();
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if ({predict_hit, predict_miss, btbpht_we, pht_wcond} !== 4'b0 ||
            predict_tag !== 5'd0 || redirect_pc !== 32'd0 ||
            btbpht_pc !== 32'd0 || btb_jmpdst !== 32'd0 ||
            pht_bhr !== '0 || mpft_valid !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs got hit=%b miss=%b we=%b vld=%b want 0",
                     predict_hit, predict_miss, btbpht_we, mpft_valid);
        end
        i_resetn = 1'b1;
        #1;
        checks++;
        if (spectagnow !== 5'b00001 || alloc_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_spectag got %b rdy=%b want 00001 rdy=1",
                     spectagnow, alloc_ready);
        end
    endtask

    task automatic test_basic_hit();
        do_alloc(32'h100, 1'b1, 32'h200, 8'h03);
        #1;
        checks++;
        if (alloc_tag !== 5'b00001 || alloc_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_alloc_tag got %b want 00001", alloc_tag);
        end
        cyc();
        checks++;
        if (spectagnow !== 5'b00010 || mpft_valid !== 5'b00001) begin
            errors++;
            $display("FAIL basic_spectag got %b vld=%b want 00010 00001",
                     spectagnow, mpft_valid);
        end
        do_res(5'b00001, 1'b1, 32'h200);
        cyc();
        checks++;
        if (predict_hit !== 1'b1 || predict_miss !== 1'b0 ||
            predict_tag !== 5'b00001 || btbpht_we !== 1'b1 ||
            btbpht_pc !== 32'h100 || btb_jmpdst !== 32'h200 ||
            pht_wcond !== 1'b1 || pht_bhr !== 8'h03 ||
            mpft_valid !== 5'd0 || redirect_pc !== 32'd0) begin
            errors++;
            $display("FAIL basic_hit got hit=%b we=%b pc=%h bhr=%h vld=%b want 1 1 100 03 0",
                     predict_hit, btbpht_we, btbpht_pc, pht_bhr, mpft_valid);
        end
        cyc();
        checks++;
        if (predict_hit !== 1'b0 || btbpht_we !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse_len got hit=%b we=%b want 0 0",
                     predict_hit, btbpht_we);
        end
    endtask

    task automatic test_mispredict();
        do_alloc(32'h120, 1'b0, 32'h0, 8'h11); cyc();
        do_alloc(32'h140, 1'b1, 32'h180, 8'h22); cyc();
        do_alloc(32'h160, 1'b1, 32'h1a0, 8'h33); cyc();
        checks++;
        if (mpft_valid !== 5'b00111) begin
            errors++;
            $display("FAIL misp_fill got %b want 00111", mpft_valid);
        end
        do_res(5'b00010, 1'b0, 32'h0);
        #1;
        checks++;
        if (alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL misp_ready got %b want 0", alloc_ready);
        end
        cyc();
        checks++;
        if (predict_miss !== 1'b1 || predict_hit !== 1'b0 ||
            predict_tag !== 5'b00010 || redirect_pc !== 32'h144 ||
            mpft_valid !== 5'b00001 || pht_bhr !== 8'h22) begin
            errors++;
            $display("FAIL misp_result got miss=%b tag=%b redir=%h vld=%b want 1 00010 144 00001",
                     predict_miss, predict_tag, redirect_pc, mpft_valid);
        end
        do_res(5'b00001, 1'b0, 32'h0);
        cyc();
        checks++;
        if (predict_hit !== 1'b1 || mpft_valid !== 5'd0) begin
            errors++;
            $display("FAIL misp_cleanup got hit=%b vld=%b want 1 0",
                     predict_hit, mpft_valid);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            do_alloc(32'h400 + 32'(i * 16), 1'b1, 32'h1000, 8'(i));
            #1;
            checks++;
            if (alloc_tag !== 5'(1 << i)) begin
                errors++;
                $display("FAIL full_alloc%0d got %b want %b",
                         i, alloc_tag, 5'(1 << i));
            end
            cyc();
        end
        alloc_req = 1'b1;
        #1;
        checks++;
        if (alloc_ready !== 1'b0 || spectagnow !== 5'd0 ||
            alloc_tag !== 5'd0 || mpft_valid !== 5'b11111) begin
            errors++;
            $display("FAIL full_stall got rdy=%b spec=%b tag=%b want 0 0 0",
                     alloc_ready, spectagnow, alloc_tag);
        end
        do_res(5'b00100, 1'b1, 32'h1000);
        #1;
        checks++;
        if (alloc_ready !== 1'b0 || spectagnow !== 5'd0) begin
            errors++;
            $display("FAIL full_freed_early got rdy=%b spec=%b want 0 0",
                     alloc_ready, spectagnow);
        end
        cyc();
        checks++;
        if (spectagnow !== 5'b00100 || predict_hit !== 1'b1 ||
            mpft_valid !== 5'b11011) begin
            errors++;
            $display("FAIL full_free got spec=%b hit=%b vld=%b want 00100 1 11011",
                     spectagnow, predict_hit, mpft_valid);
        end
        do_alloc(32'h500, 1'b1, 32'h1000, 8'h55);
        #1;
        checks++;
        if (alloc_tag !== 5'b00100) begin
            errors++;
            $display("FAIL full_realloc got %b want 00100", alloc_tag);
        end
        cyc();
    endtask

    task automatic test_ignored();
        do_res(5'b10000, 1'b0, 32'h0);
        cyc();
        checks++;
        if (predict_miss !== 1'b1 || mpft_valid !== 5'b01011) begin
            errors++;
            $display("FAIL flush_younger got miss=%b vld=%b want 1 01011",
                     predict_miss, mpft_valid);
        end
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: do_res(5'b00011, 1'b0, 32'h0);
                1: do_res(5'b00100, 1'b0, 32'h0);
                default: do_res(5'b00000, 1'b1, 32'h0);
            endcase
            cyc();
            checks++;
            if (predict_hit !== 1'b0 || predict_miss !== 1'b0 ||
                btbpht_we !== 1'b0 || mpft_valid !== 5'b01011) begin
                errors++;
                $display("FAIL ignored%0d got hit=%b miss=%b we=%b vld=%b want 0 0 0 01011",
                         i, predict_hit, predict_miss, btbpht_we, mpft_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_res(5'b01000, 1'b1, 32'h2000);
        do_alloc(32'h600, 1'b1, 32'h1000, 8'h66);
        #1;
        checks++;
        if (alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_miss_ready got %b want 0", alloc_ready);
        end
        cyc();
        checks++;
        if (predict_miss !== 1'b1 || redirect_pc !== 32'h2000 ||
            mpft_valid !== 5'b00011) begin
            errors++;
            $display("FAIL b2b_miss got miss=%b redir=%h vld=%b want 1 2000 00011",
                     predict_miss, redirect_pc, mpft_valid);
        end
        do_res(5'b00010, 1'b1, 32'h1000);
        do_alloc(32'h700, 1'b1, 32'h1000, 8'h77);
        #1;
        checks++;
        if (alloc_ready !== 1'b1 || alloc_tag !== 5'b00100) begin
            errors++;
            $display("FAIL b2b_hit_alloc got rdy=%b tag=%b want 1 00100",
                     alloc_ready, alloc_tag);
        end
        cyc();
        checks++;
        if (predict_hit !== 1'b1 || mpft_valid !== 5'b00101) begin
            errors++;
            $display("FAIL b2b_both got hit=%b vld=%b want 1 00101",
                     predict_hit, mpft_valid);
        end
        do_alloc(32'h800, 1'b1, 32'h1000, 8'h88);
        cyc();
        do_res(5'b00010, 1'b0, 32'h0);
        cyc();
        checks++;
        if (predict_miss !== 1'b1 || mpft_valid !== 5'b00101) begin
            errors++;
            $display("FAIL b2b_mask got miss=%b vld=%b want 1 00101",
                     predict_miss, mpft_valid);
        end
        do_res(5'b00001, 1'b0, 32'h0);
        cyc();
        checks++;
        if (mpft_valid !== 5'd0) begin
            errors++;
            $display("FAIL b2b_flush_all got %b want 0", mpft_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_alloc(32'h900, 1'b1, 32'h1000, 8'h99);
        cyc();
        do_res(5'b00001, 1'b1, 32'h1000);
        #3;
        i_resetn = 1'b0;
        #1;
        checks++;
        if (mpft_valid !== 5'd0 || predict_hit !== 1'b0 ||
            btbpht_we !== 1'b0 || btbpht_pc !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_async got vld=%b hit=%b we=%b want 0",
                     mpft_valid, predict_hit, btbpht_we);
        end
        cyc();
        i_resetn = 1'b1;
        cyc();
        checks++;
        if (predict_hit !== 1'b0 || predict_miss !== 1'b0 ||
            btbpht_we !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_pulse got hit=%b miss=%b want 0 0",
                     predict_hit, predict_miss);
        end
        do_alloc(32'ha00, 1'b0, 32'h0, 8'haa);
        #1;
        checks++;
        if (alloc_tag !== 5'b00001) begin
            errors++;
            $display("FAIL rstmid_first_tag got %b want 00001", alloc_tag);
        end
        cyc();
    endtask

    task automatic test_random();
        int k;
        logic [4:0] etag;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 60)
                do_alloc($urandom & 32'hffff_fffc, 1'($urandom),
                         32'h100 * $urandom_range(0, 3), 8'($urandom));
            if ($urandom_range(0, 99) < 55) begin
                k = $urandom_range(0, 4);
                if ($urandom_range(0, 9) == 0)
                    do_res(5'($urandom), 1'($urandom), 32'h0);
                else
                    do_res(5'(1 << k), 1'($urandom),
                           ($urandom_range(0, 9) < 7) ? m_tgt[k]
                           : 32'h100 * $urandom_range(0, 3));
            end
            #1;
            k = m_free_idx();
            etag = (k >= 0) ? 5'(1 << k) : 5'd0;
            checks++;
            if (alloc_tag !== etag || spectagnow !== etag ||
                alloc_ready !== ((k >= 0) && !m_miss_now())) begin
                errors++;
                $display("FAIL rnd_alloc n=%0d got tag=%b spec=%b rdy=%b want %b",
                         n, alloc_tag, spectagnow, alloc_ready, etag);
            end
            cyc();
            checks++;
            if (predict_hit !== e_hit || predict_miss !== e_miss ||
                predict_tag !== e_tag || redirect_pc !== e_redir) begin
                errors++;
                $display("FAIL rnd_result n=%0d got %b%b %b %h want %b%b %b %h",
                         n, predict_hit, predict_miss, predict_tag, redirect_pc,
                         e_hit, e_miss, e_tag, e_redir);
            end
            checks++;
            if (btbpht_we !== e_we || btbpht_pc !== e_bpc ||
                btb_jmpdst !== e_jmp || pht_wcond !== e_wcond ||
                pht_bhr !== e_bhr) begin
                errors++;
                $display("FAIL rnd_update n=%0d got %b %h %h %b %h want %b %h %h %b %h",
                         n, btbpht_we, btbpht_pc, btb_jmpdst, pht_wcond, pht_bhr,
                         e_we, e_bpc, e_jmp, e_wcond, e_bhr);
            end
            checks++;
            if (mpft_valid !== m_vec()) begin
                errors++;
                $display("FAIL rnd_valid n=%0d got %b want %b",
                         n, mpft_valid, m_vec());
            end
        end
    endtask

    initial begin
        m_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            m_pc[i] = '0; m_cond[i] = 1'b0; m_tgt[i] = '0;
            m_bhr[i] = '0; m_seq[i] = 0;
        end
        test_reset();
        test_basic_hit();
        test_mispredict();
        test_full();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
